// File: rtl/cmp_pkg.sv
// Shared types for the sequential word comparator: FSM states and the
// per-digit compare result.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    CMP_EQ,
    CMP_GT1,
    CMP_GT2
  } cmp_res_t;

endpackage

// File: rtl/digit_cmp2.sv
// Combinational unsigned compare of one 2-bit digit pair.
module digit_cmp2
  import cmp_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output cmp_res_t   res
);

  always_comb begin
    if (a > b) begin
      res = CMP_GT1;
    end else if (a < b) begin
      res = CMP_GT2;
    end else begin
      res = CMP_EQ;
    end
  end

endmodule

// File: rtl/seq_word_comparator.sv
// Multi-cycle unsigned magnitude comparator: scans one 2-bit digit per cycle,
// MSB digit first, stopping at the first difference; valid/ready on both sides.
module seq_word_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in1,
  input  logic [WIDTH-1:0]               in2,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           in1greater,
  output logic                           in2greater,
  output logic                           equal,
  output logic [$clog2(WIDTH/2+1)-1:0]   ndig,
  output logic                           busy
);

  localparam int unsigned DIGITS = WIDTH / 2;
  localparam int unsigned CntW   = $clog2(DIGITS + 1);
  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t            state_q;
  logic [WIDTH-1:0]  op1_q, op2_q;
  logic [IdxW-1:0]   idx_q;
  logic [CntW-1:0]   cnt_q;
  logic              gt1_q, gt2_q, eq_q;
  logic [CntW-1:0]   ndig_q;

  logic [1:0]        dig1, dig2;
  cmp_res_t          dig_res;

  // {idx, 0} is the LSB position of the selected digit.
  always_comb begin
    dig1 = op1_q[{idx_q, 1'b0} +: 2];
    dig2 = op2_q[{idx_q, 1'b0} +: 2];
  end

  digit_cmp2 u_digit_cmp2 (
    .a   (dig1),
    .b   (dig2),
    .res (dig_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gt1_q   <= 1'b0;
      gt2_q   <= 1'b0;
      eq_q    <= 1'b0;
      ndig_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op1_q   <= in1;
            op2_q   <= in2;
            idx_q   <= IdxW'(DIGITS - 1);
            cnt_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          cnt_q <= cnt_q + 1'b1;
          unique case (dig_res)
            CMP_GT1: begin
              gt1_q   <= 1'b1;
              ndig_q  <= cnt_q + 1'b1;
              state_q <= DONE;
            end
            CMP_GT2: begin
              gt2_q   <= 1'b1;
              ndig_q  <= cnt_q + 1'b1;
              state_q <= DONE;
            end
            default: begin
              if (idx_q == '0) begin
                eq_q    <= 1'b1;
                ndig_q  <= CntW'(DIGITS);
                state_q <= DONE;
              end else begin
                idx_q <= idx_q - 1'b1;
              end
            end
          endcase
        end
        DONE: begin
          if (out_ready) begin
            gt1_q   <= 1'b0;
            gt2_q   <= 1'b0;
            eq_q    <= 1'b0;
            ndig_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    busy       = (state_q == SCAN) || (state_q == DONE);
    in1greater = gt1_q;
    in2greater = gt2_q;
    equal      = eq_q;
    ndig       = ndig_q;
  end

endmodule

// File: tb/tb_seq_word_comparator.sv
// Directed self-checking bench for seq_word_comparator (WIDTH=16).
module tb_seq_word_comparator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1, in2;
  logic        out_valid;
  logic        out_ready;
  logic        in1greater, in2greater, equal;
  logic [3:0]  ndig;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [2:0] R_GT1 = 3'b100;
  localparam logic [2:0] R_GT2 = 3'b010;
  localparam logic [2:0] R_EQ  = 3'b001;

  seq_word_comparator #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .in1greater (in1greater),
    .in2greater (in2greater),
    .equal      (equal),
    .ndig       (ndig),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE: accept, wait for result, check, drain.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int exp_m, input logic [2:0] exp_res);
    int   lat;
    logic ready_seen;
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    ready_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_seen = 1'b1;
      tick();
      lat++;
    end
    chk({tag, ":latency"}, lat, exp_m);
    chk({tag, ":in_ready_low"}, {ready_seen, in_ready}, 2'b00);
    chk({tag, ":result"}, {in1greater, in2greater, equal}, exp_res);
    chk({tag, ":ndig"}, ndig, exp_m);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ":idle"}, {in_ready, out_valid, busy}, 3'b100);
    chk({tag, ":cleared"}, {in1greater, in2greater, equal, ndig}, 7'd0);
  endtask

  initial begin
    int   k;
    logic [2:0] res;
    logic [3:0] nd;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in1       = '0;
    in2       = '0;
    #1;
    chk("reset:hs", {in_ready, out_valid, busy}, 3'b100);
    chk("reset:res", {in1greater, in2greater, equal, ndig}, 7'd0);
    #12;
    rst_n = 1'b1;
    tick();

    // Basic compares: first-digit difference, full-equal scan, late and mid differences.
    run_op("gt1_msb", 16'h8000, 16'h7FFF, 1, R_GT1);
    run_op("eq_a5a5", 16'hA5A5, 16'hA5A5, 8, R_EQ);
    run_op("gt2_lsb", 16'h1234, 16'h1235, 8, R_GT2);
    run_op("gt2_d4",  16'h0000, 16'h0100, 4, R_GT2);
    run_op("gt1_d5",  16'h00C0, 16'h0080, 5, R_GT1);

    // Result held under backpressure while in_valid is pulsed.
    in1 = 16'h8000;
    in2 = 16'h7FFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in1 = 16'h0000;
      in2 = 16'hFFFF;
      chk("hold:valid_ready", {out_valid, in_ready}, 2'b10);
      chk("hold:result", {in1greater, in2greater, equal}, R_GT1);
      chk("hold:ndig", ndig, 4'd1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold:release", {in_ready, out_valid, busy}, 3'b100);
    chk("hold:cleared", {in1greater, in2greater, equal, ndig}, 7'd0);
    tick();
    chk("hold:no_capture", {busy, in_ready}, 2'b01);

    // Asynchronous reset during the third SCAN cycle.
    in1 = 16'h5555;
    in2 = 16'h5555;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("rst:in_scan", {busy, out_valid}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("rst:hs", {in_ready, out_valid, busy}, 3'b100);
    chk("rst:res", {in1greater, in2greater, equal, ndig}, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("post_rst", 16'h0003, 16'h0002, 8, R_GT1);

    // Streaming with in_valid and out_ready held high.
    in1 = 16'hFFFF;
    in2 = 16'h0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in1 = 16'h0001;
    in2 = 16'h0001;
    k = 0;
    res = '0;
    nd = '0;
    while (!in_ready && k < 40) begin
      if (out_valid) begin
        res = {in1greater, in2greater, equal};
        nd  = ndig;
      end
      tick();
      k++;
    end
    chk("stream1:period", k + 1, 3);
    chk("stream1:result", res, R_GT1);
    chk("stream1:ndig", nd, 4'd1);
    tick();
    in_valid = 1'b0;
    k = 0;
    res = '0;
    nd = '0;
    while (!in_ready && k < 40) begin
      if (out_valid) begin
        res = {in1greater, in2greater, equal};
        nd  = ndig;
      end
      tick();
      k++;
    end
    out_ready = 1'b0;
    chk("stream2:period", k + 1, 10);
    chk("stream2:result", res, R_EQ);
    chk("stream2:ndig", nd, 4'd8);
    tick();
    chk("stream:idle", {in_ready, busy}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
